// File: rtl/bash_sponge_if.sv
// Message-in / hash-out handshake bundle for the bash sponge controller.
// Widths are derived from the security level L so both sides always agree.
interface bash_sponge_if #(
  parameter int L = 128
);
  localparam int RATE = 1536 - 4 * L;
  localparam int HASH = 2 * L;
  localparam int NBW  = $clog2(RATE / 8 + 1);

  logic            in_valid;
  logic            in_ready;
  logic [RATE-1:0] in_data;
  logic            in_last;
  logic [NBW-1:0]  in_nbytes;
  logic            hash_valid;
  logic            hash_ready;
  logic [HASH-1:0] hash_data;

  modport master (
    output in_valid, in_data, in_last, in_nbytes, hash_ready,
    input  in_ready, hash_valid, hash_data
  );

  modport slave (
    input  in_valid, in_data, in_last, in_nbytes, hash_ready,
    output in_ready, hash_valid, hash_data
  );
endinterface

// File: rtl/bash_sponge_ctrl.sv
// Sponge controller for bash-hash: pads and loads message blocks, sequences
// bash_f_iter for ROUNDS clocks per block and presents the 2L-bit hash.
module bash_sponge_ctrl #(
  parameter int L      = 128,
  parameter int ROUNDS = 24
) (
  input  logic          clk,
  input  logic          rst,
  bash_sponge_if.slave  bus,
  output logic          f_data_sel,
  output logic [1535:0] f_data_o,
  input  logic [1535:0] f_data_i,
  output logic          busy
);
  localparam int RATE = 1536 - 4 * L;
  localparam int HASH = 2 * L;
  localparam int NBW  = $clog2(RATE / 8 + 1);
  localparam int CAP  = 1536 - RATE;
  localparam int NB   = RATE / 8;
  localparam int CW   = $clog2(ROUNDS + 1);

  localparam logic [1535:0] IV      = {{(1536 - 64){1'b0}}, 64'(L / 4)};
  // Pad-only block: 0x40 in byte 0, which is the low byte of word 0.
  localparam logic [RATE-1:0] PAD_BLK = {56'd0, 8'h40, {(RATE - 64){1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_CAPT,
    ST_DONE
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;
  logic [1535:0]   s_reg;
  logic [1535:0]   f_data_reg;
  logic            pad_pend_reg;
  logic            last_reg;

  logic            in_ready_c;
  logic            hash_valid_c;
  logic            f_sel_c;
  logic            busy_c;
  logic            accept;
  logic [NBW-1:0]  n_sat;
  logic            pad_full;
  logic [RATE-1:0] blk;

  assign n_sat    = (bus.in_nbytes > NBW'(NB)) ? NBW'(NB) : bus.in_nbytes;
  assign pad_full = bus.in_last && (n_sat == NBW'(NB));
  assign accept   = bus.in_valid && in_ready_c;

  // Byte k lives in word k/8 (word 0 on top), little-endian within the word.
  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_byte
      localparam int POS = RATE - 64 * (gi / 8 + 1) + 8 * (gi % 8);
      localparam logic [NBW-1:0] IDX = NBW'(gi);
      assign blk[POS +: 8] = (!bus.in_last || (IDX < n_sat)) ? bus.in_data[POS +: 8] :
                             ((IDX == n_sat) ? 8'h40 : 8'h00);
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    in_ready_c   = 1'b0;
    hash_valid_c = 1'b0;
    f_sel_c      = 1'b0;
    busy_c       = 1'b1;
    case (state_reg)
      ST_IDLE: begin
        in_ready_c = 1'b1;
        busy_c     = 1'b0;
        if (bus.in_valid) begin
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_next = ST_RUN;
        cnt_next   = CW'(1);
      end
      ST_RUN: begin
        f_sel_c = 1'b1;
        if (cnt_reg == CW'(ROUNDS - 1)) begin
          state_next = ST_CAPT;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      ST_CAPT: begin
        if (pad_pend_reg) begin
          state_next = ST_LOAD;
        end else if (last_reg) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_DONE: begin
        hash_valid_c = 1'b1;
        if (bus.hash_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // The block replaces the rate part outright; only the capacity part carries over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_reg        <= IV;
      f_data_reg   <= IV;
      pad_pend_reg <= 1'b0;
      last_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            f_data_reg   <= {blk, s_reg[CAP-1:0]};
            pad_pend_reg <= pad_full;
            last_reg     <= bus.in_last;
          end
        end
        ST_CAPT: begin
          s_reg <= f_data_i;
          if (pad_pend_reg) begin
            f_data_reg   <= {PAD_BLK, f_data_i[CAP-1:0]};
            pad_pend_reg <= 1'b0;
          end
        end
        ST_DONE: begin
          if (bus.hash_ready) begin
            s_reg      <= IV;
            f_data_reg <= IV;
            last_reg   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.hash_valid = hash_valid_c;
  assign bus.hash_data  = s_reg[1535 -: HASH];
  assign f_data_sel     = f_sel_c;
  assign f_data_o       = f_data_reg;
  assign busy           = busy_c;
endmodule

// File: tb/tb_bash_sponge_ctrl.sv
// Scoreboard bench for bash_sponge_ctrl with a rotate-xor stand-in for bash_f_iter.
// Stimulus pushes expected hashes; a monitor pops and compares on each handshake.
module tb_bash_sponge_ctrl;
  localparam int L      = 128;
  localparam int ROUNDS = 24;
  localparam int RATE   = 1024;
  localparam int HASH   = 256;
  localparam int NB     = 128;
  localparam int CAP    = 512;

  localparam logic [1535:0] IV         = {1472'd0, 64'd32};
  localparam logic [1535:0] EMPTY_LOAD = {64'h40, 1408'd0, 64'd32};
  localparam logic [63:0]   K          = 64'hA5A5_A5A5_A5A5_A5A5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bash_sponge_if #(.L(L)) bus ();
  logic          f_data_sel;
  logic          busy;
  logic [1535:0] f_data_o;
  logic [1535:0] f_data_i;
  logic [1535:0] stub_reg;

  bash_sponge_ctrl #(.L(L), .ROUNDS(ROUNDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .f_data_sel (f_data_sel),
    .f_data_o   (f_data_o),
    .f_data_i   (f_data_i),
    .busy       (busy)
  );

  function automatic logic [1535:0] stub_round(input logic [1535:0] x);
    return {x[1534:0], x[1535]} ^ {24{K}};
  endfunction

  // Stand-in permutation: latch on sel=0, one round per sel=1 clock.
  always @(posedge clk) stub_reg <= f_data_sel ? stub_round(stub_reg) : f_data_o;
  assign f_data_i = stub_reg;

  int checks   = 0;
  int failures = 0;
  logic [1535:0] model_s;
  logic [HASH-1:0] exp_q[$];
  logic [HASH-1:0] empty_hash;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_wide(input string name, input logic [1535:0] act, input logic [1535:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      for (int i = 0; i < 24; i++) begin
        if (act[1535-64*i -: 64] !== exp[1535-64*i -: 64]) begin
          $display("FAIL %s word%0d actual=%h required=%h", name, i,
                   act[1535-64*i -: 64], exp[1535-64*i -: 64]);
          break;
        end
      end
    end
  endtask

  function automatic int bpos(input int k);
    return RATE - 64 * (k / 8 + 1) + 8 * (k % 8);
  endfunction

  function automatic logic [1535:0] perm(input logic [1535:0] x);
    logic [1535:0] y = x;
    for (int i = 0; i < ROUNDS - 1; i++) y = stub_round(y);
    return y;
  endfunction

  function automatic logic [RATE-1:0] gen(input int seed);
    logic [RATE-1:0] b;
    for (int w = 0; w < 16; w++)
      b[RATE-1-64*w -: 64] = 64'h0123_4567_89AB_CDEF ^ (64'(seed) * 64'h9E37_79B9_7F4A_7C15) ^ 64'(w);
    return b;
  endfunction

  task automatic model_absorb(input logic [RATE-1:0] data, input logic last, input int n);
    logic [RATE-1:0] b = data;
    int nn = (n > NB) ? NB : n;
    if (last && nn < NB)
      for (int k = nn; k < NB; k++) b[bpos(k) +: 8] = (k == nn) ? 8'h40 : 8'h00;
    model_s = perm({b, model_s[CAP-1:0]});
    if (last && nn == NB) begin
      b = '0;
      b[bpos(0) +: 8] = 8'h40;
      model_s = perm({b, model_s[CAP-1:0]});
    end
    if (last) begin
      exp_q.push_back(model_s[1535 -: HASH]);
      model_s = IV;
    end
  endtask

  // Called at a negedge; returns at the negedge right after the accepting edge.
  task automatic send_block(input logic [RATE-1:0] data, input logic last, input int n);
    int t = 0;
    while (!bus.in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!bus.in_ready) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
      return;
    end
    bus.in_valid  = 1'b1;
    bus.in_data   = data;
    bus.in_last   = last;
    bus.in_nbytes = 8'(n);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    model_absorb(data, last, n);
  endtask

  task automatic wait_hash(input int start, input int exp_lat, input string name);
    int c = start;
    while (!bus.hash_valid && c < start + 200) begin
      @(negedge clk);
      c++;
    end
    check(name, 256'(c), 256'(exp_lat));
  endtask

  // Monitor: compares every handshake with the scoreboard and checks hold stability.
  logic            prev_valid = 1'b0;
  logic            prev_ready = 1'b0;
  logic [HASH-1:0] prev_data  = '0;
  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (prev_valid && !prev_ready) begin
        check("hold_valid", 256'(bus.hash_valid), 256'd1);
        check("hold_data", bus.hash_data, prev_data);
      end
      if (bus.hash_valid && bus.hash_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL hash_unexpected actual=%0h required=none", bus.hash_data);
        end else begin
          check("hash", bus.hash_data, exp_q.pop_front());
        end
      end
    end
    prev_valid = bus.hash_valid && !rst;
    prev_ready = bus.hash_ready;
    prev_data  = bus.hash_data;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [RATE-1:0] d;
    int accepts;
    int t;
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_last    = 1'b0;
    bus.in_nbytes  = '0;
    bus.hash_ready = 1'b1;
    model_s        = IV;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 256'(bus.in_ready), 256'd1);
    check("rst_hash_valid", 256'(bus.hash_valid), 256'd0);
    check("rst_sel", 256'(f_data_sel), 256'd0);
    check("rst_busy", 256'(busy), 256'd0);
    check_wide("rst_f_data_o", f_data_o, IV);
    rst = 1'b0;
    @(negedge clk);

    // Empty message: one pad block, one permutation
    send_block('0, 1'b1, 0);
    empty_hash = exp_q[$];
    check_wide("empty_load", f_data_o, EMPTY_LOAD);
    check("empty_load_sel", 256'(f_data_sel), 256'd0);
    wait_hash(0, 25, "empty_lat");
    @(negedge clk);

    // Block timing: LOAD, 23 RUN clocks, CAPT, then ready again
    send_block(gen(1), 1'b0, 0);
    check("t1_sel_c0", 256'(f_data_sel), 256'd0);
    check("t1_ready_c0", 256'(bus.in_ready), 256'd0);
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      check($sformatf("t1_sel_c%0d", c), 256'(f_data_sel), 256'(c <= 23));
      check($sformatf("t1_ready_c%0d", c), 256'(bus.in_ready), 256'(c == 25));
    end
    send_block(gen(2), 1'b1, 5);
    wait_hash(0, 25, "t1_final_lat");
    @(negedge clk);

    // n = 127: pad lands in byte 127, single permutation
    d = gen(3);
    send_block(d, 1'b1, 127);
    check("n127_byte127", 256'(f_data_o[CAP + 56 +: 8]), 256'h40);
    check("n127_byte126", 256'(f_data_o[CAP + 48 +: 8]), 256'(d[48 +: 8]));
    wait_hash(0, 25, "n127_lat");
    @(negedge clk);

    // n = 128: data block then a separate 0x40 pad block
    d = gen(4);
    send_block(d, 1'b1, 128);
    check("n128_byte127", 256'(f_data_o[CAP + 56 +: 8]), 256'(d[56 +: 8]));
    repeat (25) @(negedge clk);
    check_wide("n128_pad_blk", 1536'(f_data_o[1535:CAP]), 1536'({64'h40, 960'd0}));
    check("n128_pad_sel", 256'(f_data_sel), 256'd0);
    wait_hash(25, 50, "n128_lat");
    @(negedge clk);

    // Multi-block message, consumer stalls for 10 cycles
    bus.hash_ready = 1'b0;
    for (int b = 0; b < 3; b++) send_block(gen(10 + b), 1'b0, 0);
    send_block(gen(13), 1'b1, 5);
    wait_hash(0, 25, "multi_lat");
    repeat (10) @(negedge clk);
    check("multi_stall_valid", 256'(bus.hash_valid), 256'd1);
    bus.hash_ready = 1'b1;
    @(negedge clk);
    check("multi_post_ready", 256'(bus.in_ready), 256'd1);
    check("multi_post_busy", 256'(busy), 256'd0);
    check_wide("multi_post_iv", f_data_o, IV);

    // Reset in the middle of RUN discards the partial message
    send_block(gen(20), 1'b0, 0);
    repeat (12) @(negedge clk);
    check("rst_mid_pre_sel", 256'(f_data_sel), 256'd1);
    rst = 1'b1;
    #1;
    check("rst_mid_ready", 256'(bus.in_ready), 256'd1);
    check("rst_mid_sel", 256'(f_data_sel), 256'd0);
    check("rst_mid_hash_valid", 256'(bus.hash_valid), 256'd0);
    check_wide("rst_mid_iv", f_data_o, IV);
    model_s = IV;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_block('0, 1'b1, 0);
    check("rst_then_empty_exp", exp_q[$], empty_hash);
    wait_hash(0, 25, "rst_then_empty_lat");
    @(negedge clk);

    // in_valid held high while busy: one accept per ROUNDS+2 clocks
    d = gen(30);
    bus.in_data   = d;
    bus.in_last   = 1'b0;
    bus.in_nbytes = '0;
    bus.in_valid  = 1'b1;
    accepts = 0;
    for (int i = 0; i < 60; i++) begin
      if (bus.in_valid && bus.in_ready) accepts++;
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    check("held_valid_accepts", 256'(accepts), 256'd3);
    for (int i = 0; i < 3; i++) model_absorb(d, 1'b0, 0);
    send_block('0, 1'b1, 0);
    wait_hash(0, 25, "held_final_lat");
    @(negedge clk);

    t = 0;
    while (exp_q.size() > 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("scoreboard_drained", 256'(exp_q.size()), 256'd0);
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
